// File: rtl/mesi_isc_breq_arb_cntl.sv
// mesi_isc_breq_arb_cntl: breq ack/ID generation and round-robin broad arbiter; MESI_ISC_BREQ_ARB_STATS_EN adds per-CPU grant counters
`timescale 1ns/1ps
module mesi_isc_breq_arb_cntl #(
  parameter int NUM_CPUS = 4,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH = 7,
  localparam int CPU_ID_WIDTH = $clog2(NUM_CPUS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
  input  logic [NUM_CPUS-1:0] cpu_en_i,
  input  logic [NUM_CPUS-1:0] fifo_status_empty_array_i,
  input  logic [NUM_CPUS-1:0] fifo_status_full_array_i,
  input  logic broad_fifo_status_full_i,
  input  logic [NUM_CPUS*ADDR_WIDTH-1:0] broad_addr_array_i,
  input  logic [NUM_CPUS*BROAD_TYPE_WIDTH-1:0] broad_type_array_i,
  input  logic [NUM_CPUS*BROAD_ID_WIDTH-1:0] broad_id_array_i,
  output logic [NUM_CPUS-1:0] mbus_ack_array_o,
  output logic [NUM_CPUS-1:0] fifo_wr_array_o,
  output logic [NUM_CPUS-1:0] fifo_rd_array_o,
  output logic broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0] broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0] broad_type_o,
  output logic [CPU_ID_WIDTH-1:0] broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0] broad_id_o,
  output logic [NUM_CPUS*BROAD_TYPE_WIDTH-1:0] breq_type_array_o,
  output logic [NUM_CPUS*CPU_ID_WIDTH-1:0] breq_cpu_id_array_o,
  output logic [NUM_CPUS*BROAD_ID_WIDTH-1:0] breq_id_array_o
`ifdef MESI_ISC_BREQ_ARB_STATS_EN
  ,
  output logic [NUM_CPUS*16-1:0] grant_cnt_array_o
`endif
);
  localparam logic [MBUS_CMD_WIDTH-1:0] MESI_ISC_MBUS_CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MESI_ISC_MBUS_CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_NOP = BROAD_TYPE_WIDTH'(0);
  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_WR = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_RD = BROAD_TYPE_WIDTH'(2);
  localparam int IDB_WIDTH = BROAD_ID_WIDTH - CPU_ID_WIDTH;
  logic [NUM_CPUS-1:0] elig, sel, ack_nxt;
  logic [NUM_CPUS*BROAD_TYPE_WIDTH-1:0] type_nxt;
  logic [CPU_ID_WIDTH-1:0] rr_ptr, gnt_idx, idx;
  logic [MBUS_CMD_WIDTH-1:0] cmd;
  logic any_gnt;
  logic [IDB_WIDTH-1:0] id_base;
  assign elig = ~fifo_status_empty_array_i & cpu_en_i;
  // descending scan so the last hit kept is the nearest one at or after rr_ptr
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx = '0;
    for (int k = NUM_CPUS - 1; k >= 0; k--) begin
      idx = rr_ptr + CPU_ID_WIDTH'(k);
      if (elig[idx]) begin
        gnt_idx = idx;
        any_gnt = 1'b1;
      end
    end
  end
  assign sel = any_gnt ? NUM_CPUS'(1) << gnt_idx : '0;
  assign fifo_rd_array_o = sel & {NUM_CPUS{~broad_fifo_status_full_i}};
  assign broad_fifo_wr_o = |fifo_rd_array_o;
  assign fifo_wr_array_o = mbus_ack_array_o;
  assign broad_cpu_id_o = gnt_idx;
  assign broad_addr_o = any_gnt ? broad_addr_array_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign broad_type_o = any_gnt ? broad_type_array_i[gnt_idx*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] : '0;
  assign broad_id_o = any_gnt ? broad_id_array_i[gnt_idx*BROAD_ID_WIDTH +: BROAD_ID_WIDTH] : '0;
  always_comb begin
    ack_nxt = '0;
    type_nxt = '0;
    cmd = '0;
    breq_cpu_id_array_o = '0;
    breq_id_array_o = '0;
    for (int c = 0; c < NUM_CPUS; c++) begin
      cmd = mbus_cmd_array_i[c*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      ack_nxt[c] = cpu_en_i[c] && (cmd == MESI_ISC_MBUS_CMD_WR_BROAD || cmd == MESI_ISC_MBUS_CMD_RD_BROAD)
                   && !fifo_status_full_array_i[c] && !mbus_ack_array_o[c];
      type_nxt[c*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] = cmd == MESI_ISC_MBUS_CMD_WR_BROAD ? MESI_ISC_BREQ_TYPE_WR :
                                                         cmd == MESI_ISC_MBUS_CMD_RD_BROAD ? MESI_ISC_BREQ_TYPE_RD :
                                                         MESI_ISC_BREQ_TYPE_NOP;
      breq_cpu_id_array_o[c*CPU_ID_WIDTH +: CPU_ID_WIDTH] = CPU_ID_WIDTH'(c);
      breq_id_array_o[c*BROAD_ID_WIDTH +: BROAD_ID_WIDTH] = {id_base, CPU_ID_WIDTH'(c)};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbus_ack_array_o <= '0;
      breq_type_array_o <= {NUM_CPUS{MESI_ISC_BREQ_TYPE_NOP}};
      id_base <= '0;
      rr_ptr <= '0;
    end else begin
      mbus_ack_array_o <= ack_nxt;
      breq_type_array_o <= type_nxt;
      if (|fifo_wr_array_o) id_base <= id_base + IDB_WIDTH'(1);
      if (broad_fifo_wr_o) rr_ptr <= gnt_idx + CPU_ID_WIDTH'(1);
    end
  end
`ifdef MESI_ISC_BREQ_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_cnt_array_o <= '0;
    else
      for (int c = 0; c < NUM_CPUS; c++)
        if (fifo_rd_array_o[c] && grant_cnt_array_o[c*16 +: 16] != 16'hFFFF)
          grant_cnt_array_o[c*16 +: 16] <= grant_cnt_array_o[c*16 +: 16] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mesi_isc_breq_arb_cntl.sv
// tb_mesi_isc_breq_arb_cntl: directed vector bench for the breq arbiter, ack and ID logic
`timescale 1ns/1ps
module tb_mesi_isc_breq_arb_cntl;
  localparam logic [2:0] WR_BROAD = 3'd3, RD_BROAD = 3'd4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [11:0] cmd = '0;
  logic [3:0] en = 4'hF, empty = 4'hF, full = 4'h0;
  logic bfull = 1'b0;
  logic [127:0] addr_a;
  logic [7:0] type_a;
  logic [27:0] id_a;
  logic [3:0] ack, fwr, frd;
  logic bwr;
  logic [31:0] baddr;
  logic [1:0] btype, bcpu;
  logic [6:0] bid;
  logic [7:0] qtype, qcpu;
  logic [27:0] qid;
`ifdef MESI_ISC_BREQ_ARB_STATS_EN
  logic [63:0] gcnt;
`endif
  int errors = 0, checks = 0;
  logic [4:0] mbase = '0;
  typedef struct {
    logic [3:0] en, empty;
    logic bfull;
    logic [3:0] rd;
    logic wr, any;
    logic [1:0] id;
  } vec_t;
  vec_t vt[13];
  always #5 clk = ~clk;
  mesi_isc_breq_arb_cntl dut (
    .clk(clk), .rst_n(rst_n), .mbus_cmd_array_i(cmd), .cpu_en_i(en),
    .fifo_status_empty_array_i(empty), .fifo_status_full_array_i(full),
    .broad_fifo_status_full_i(bfull), .broad_addr_array_i(addr_a),
    .broad_type_array_i(type_a), .broad_id_array_i(id_a),
    .mbus_ack_array_o(ack), .fifo_wr_array_o(fwr), .fifo_rd_array_o(frd),
    .broad_fifo_wr_o(bwr), .broad_addr_o(baddr), .broad_type_o(btype),
    .broad_cpu_id_o(bcpu), .broad_id_o(bid), .breq_type_array_o(qtype),
    .breq_cpu_id_array_o(qcpu), .breq_id_array_o(qid)
`ifdef MESI_ISC_BREQ_ARB_STATS_EN
    , .grant_cnt_array_o(gcnt)
`endif
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    vt[0]  = '{4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    vt[1]  = '{4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    vt[2]  = '{4'hF, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    vt[3]  = '{4'hF, 4'h0, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[4]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    vt[5]  = '{4'hF, 4'h6, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    vt[6]  = '{4'hF, 4'h6, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[7]  = '{4'hF, 4'h6, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    vt[8]  = '{4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1};
    vt[9]  = '{4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    vt[10] = '{4'hB, 4'hB, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    vt[11] = '{4'hF, 4'hB, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
    vt[12] = '{4'h7, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    for (int i = 0; i < 4; i++) begin
      addr_a[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      type_a[i*2 +: 2] = 2'(3 - i);
      id_a[i*7 +: 7] = 7'h40 + 7'(i);
    end
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_fifo_wr", fwr, 0);
    chk("rst_breq_type", qtype, 0);
    chk("rst_breq_id", qid, {5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd1, 5'd0, 2'd0});
    chk("rst_breq_cpu_id", qcpu, 8'b11_10_01_00);
    chk("rst_broad_wr", bwr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      en = vt[v].en; empty = vt[v].empty; bfull = vt[v].bfull;
      #1;
      chk($sformatf("v%0d_rd", v), frd, vt[v].rd);
      chk($sformatf("v%0d_bwr", v), bwr, vt[v].wr);
      chk($sformatf("v%0d_cpu_id", v), bcpu, vt[v].id);
      chk($sformatf("v%0d_addr", v), baddr, vt[v].any ? 32'hA000_0000 + 32'(vt[v].id) : 32'h0);
      chk($sformatf("v%0d_type", v), btype, vt[v].any ? 2'(3 - vt[v].id) : 2'd0);
      chk($sformatf("v%0d_id", v), bid, vt[v].any ? 7'h40 + 7'(vt[v].id) : 7'h0);
    end
    @(negedge clk);
    empty = 4'hF; en = 4'hF; bfull = 1'b0; cmd[2:0] = WR_BROAD;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("ack0_c%0d", k), ack, 4'(k % 2));
      chk($sformatf("fifo_wr_c%0d", k), fwr, 4'(k % 2));
      chk($sformatf("type0_c%0d", k), qtype[1:0], k == 0 ? 2'd0 : 2'd1);
      chk($sformatf("id0_c%0d", k), qid[6:0], {mbase, 2'b00});
      if (k % 2 == 1) mbase++;
    end
    cmd[2:0] = 3'd0;
    for (int j = 0; j < 29; j++) begin
      @(negedge clk); cmd[2:0] = WR_BROAD;
      @(negedge clk); cmd[2:0] = 3'd0;
      mbase++;
    end
    @(negedge clk); #1;
    chk("wrap_pre_ack", ack, 0);
    chk("wrap_pre_id0", qid[6:0], {mbase, 2'b00});
    cmd[8:6] = RD_BROAD;
    @(negedge clk); #1;
    chk("wrap_ack2", ack, 4'b0100);
    chk("wrap_id2_max", qid[20:14], 7'h7E);
    chk("wrap_type2_rd", qtype[5:4], 2'd2);
    cmd[8:6] = 3'd0;
    mbase++;
    @(negedge clk); #1;
    chk("wrap_id2_zero", qid[20:14], {mbase, 2'b10});
    chk("wrap_ack_drop", ack, 0);
    en = 4'b1011; full = 4'b0010; cmd[5:3] = WR_BROAD; cmd[8:6] = WR_BROAD;
    @(negedge clk); #1;
    chk("ack_en_full_block", ack, 0);
    en = 4'hF; full = 4'h0;
    @(negedge clk); #1;
    chk("ack_unblocked", ack, 4'b0110);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_fifo_wr", fwr, 0);
    chk("midrst_type", qtype, 0);
    chk("midrst_id0", qid[6:0], 7'h0);
    @(negedge clk);
    cmd = '0;
    rst_n = 1'b1;
`ifdef MESI_ISC_BREQ_ARB_STATS_EN
    en = 4'b0001; empty = 4'b1110;
    repeat (65546) @(negedge clk);
    #1;
    chk("cnt0_sat", gcnt[15:0], 16'hFFFF);
    chk("cnt1_zero", gcnt[31:16], 16'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
